// File: rtl/fifo_arb_pkg.sv
// Shared defaults and FSM encoding for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter.
// The slave modport is the arbiter; master is whoever drives producers and wrfull.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [N-1:0]             req;
  logic [N-1:0][DATA_W-1:0] din;
  logic [N-1:0]             gnt;
  logic [N-1:0]             ack;
  logic                     wrfull;
  logic                     wrreq;
  logic [DATA_W-1:0]        data;
  logic                     busy;
  logic [$clog2(N)-1:0]     owner;

  modport master (
    output req, din, wrfull,
    input  gnt, ack, wrreq, data, busy, owner
  );

  modport slave (
    input  req, din, wrfull,
    output gnt, ack, wrreq, data, busy, owner
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit after 'last', wrapping mod N.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W-1:0] pos;
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    // scan farthest-first so the nearest hit after 'last' is the one kept
    for (int k = N; k >= 1; k--) begin
      pos = IDX_W'((int'(last) + k) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N producers.
// Grant holds until the owner drops req or MAX_BURST words are written.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q,   gnt_d;
  logic             busy_q,  busy_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             own_req;
  logic             wr_en;
  logic [N-1:0]     ack_w;
  logic [DATA_W-1:0] data_w;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .last  (owner_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign own_req = bus.req[owner_q];
  // wrfull gates the write in the same cycle; the grant itself is kept
  assign wr_en   = (state_q == ST_GRANT) & own_req & ~bus.wrfull;

  always_comb begin
    ack_w  = '0;
    data_w = '0;
    if (wr_en) begin
      ack_w[owner_q] = 1'b1;
      data_w         = bus.din[owner_q];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && !bus.wrfull) begin
          state_d         = ST_GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          busy_d          = 1'b1;
          cnt_d           = '0;
        end
      end
      ST_GRANT: begin
        // an owner that drops req on its last beat writes nothing and just releases
        if (!own_req || (wr_en && cnt_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (wr_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= LAST_IDX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;
  assign bus.wrreq = wr_en;
  assign bus.ack   = ack_w;
  assign bus.data  = data_w;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a burst-level reference model
// compared against the DUT on every negedge outside reset.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(N), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.N(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(logic [N-1:0] v, int i);
    return v[i[IW-1:0]];
  endfunction

  function automatic logic [DW-1:0] base(int i);
    return DW'(i * 64);
  endfunction

  // Producers: requester i wants target[i] words in total, sends word base+sent.
  int target[N] = '{default: 0};
  int sent[N]   = '{default: 0};
  logic [N-1:0] ack_s = '0;

  for (genvar g = 0; g < N; g++) begin : g_prod
    assign bus.req[g] = (sent[g] < target[g]);
    assign bus.din[g] = DW'(int'(base(g)) + sent[g]);
  end

  always @(negedge clk) ack_s <= bus.ack;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (bit_of(ack_s, i)) sent[i] = sent[i] + 1;
  end

  // Reference model: owner, words in the current burst, words written per requester.
  logic          m_busy  = 1'b0;
  logic [IW-1:0] m_owner = IW'(N - 1);
  int            m_cnt   = 0;
  int            m_wr[N] = '{default: 0};

  function automatic logic [IW-1:0] rr_next(logic [N-1:0] r, logic [IW-1:0] last);
    for (int k = 1; k <= N; k++) begin
      logic [IW-1:0] p;
      p = IW'((int'(last) + k) % N);
      if (r[p]) return p;
    end
    return last;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_owner <= IW'(N - 1);
      m_cnt   <= 0;
    end else if (!m_busy) begin
      if (bus.req != '0 && !bus.wrfull) begin
        m_busy  <= 1'b1;
        m_owner <= rr_next(bus.req, m_owner);
        m_cnt   <= 0;
      end
    end else if (bus.req[m_owner] && !bus.wrfull) begin
      m_wr[m_owner] <= m_wr[m_owner] + 1;
      if (m_cnt + 1 == MB) m_busy <= 1'b0;
      else                 m_cnt  <= m_cnt + 1;
    end else if (!bus.req[m_owner]) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0]  eg;
    logic          ew;
    logic [DW-1:0] ed;
    eg = m_busy ? N'(1 << m_owner) : '0;
    ew = m_busy && bus.req[m_owner] && !bus.wrfull;
    ed = ew ? DW'(int'(base(int'(m_owner))) + m_wr[m_owner]) : '0;
    if (rst_n) begin
      chk("m_gnt",   bus.gnt,   eg);
      chk("m_busy",  bus.busy,  m_busy);
      chk("m_owner", bus.owner, m_owner);
      chk("m_wrreq", bus.wrreq, ew);
      chk("m_ack",   bus.ack,   ew ? eg : '0);
      chk("m_data",  bus.data,  ed);
    end
  end

  // Grant log: owner at each rising grant.
  logic [N-1:0] prev_gnt = '0;
  int gq[$];
  always @(negedge clk) begin
    if (prev_gnt == '0 && bus.gnt != '0) gq.push_back(int'(bus.owner));
    prev_gnt <= bus.gnt;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_acks(int i, int n, string nm);
    int c = 0;
    int t = 0;
    while (c < n && t < 300) begin
      @(negedge clk);
      if (bit_of(bus.ack, i)) c++;
      t++;
    end
    chk(nm, c, n);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (sent[i] < target[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(string nm);
    int t = 0;
    while ((pending() || bus.busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(nm, {pending(), bus.busy}, 0);
  endtask

  initial begin
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int s2;
    int g0;
    bus.wrfull = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_gnt",   bus.gnt,   0);
    chk("rst_busy",  bus.busy,  0);
    chk("rst_owner", bus.owner, 3);
    chk("rst_wrreq", bus.wrreq, 0);
    chk("rst_ack",   bus.ack,   0);
    chk("rst_data",  bus.data,  0);

    // single requester, 6 words across a capped burst and a short one
    tick();
    target[1] = sent[1] + 6;
    @(negedge clk);
    chk("t1_idle_gnt", bus.gnt, 4'b0000);
    @(negedge clk);
    chk("t1_gnt",   bus.gnt,   4'b0010);
    chk("t1_wrreq", bus.wrreq, 1);
    chk("t1_data",  bus.data,  8'h40);
    wait_acks(1, 5, "t1_acks");
    wait_drain("t1_drain");
    chk("t1_end_gnt", bus.gnt, 4'b0000);

    // round robin from reset with all four requesting two bursts each
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    gq.delete();
    for (int i = 0; i < N; i++) target[i] = sent[i] + 2 * MB;
    wait_drain("t2_drain");
    chk("t2_ngrants", gq.size(), 8);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk($sformatf("t2_order%0d", i), gq[i], exp_o[i]);

    // backpressure in the middle of owner 2's burst
    tick();
    g0 = gq.size();
    s2 = sent[2];
    target[2] = sent[2] + MB;
    wait_acks(2, 2, "t3_pre");
    @(posedge clk);
    #2 bus.wrfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_wrreq%0d", i), bus.wrreq, 0);
      chk($sformatf("t3_ack%0d", i),   bus.ack,   0);
      chk($sformatf("t3_gnt%0d", i),   bus.gnt,   4'b0100);
    end
    @(posedge clk);
    #2 bus.wrfull = 1'b0;
    wait_drain("t3_drain");
    chk("t3_total",   sent[2] - s2, MB);
    chk("t3_grants",  gq.size() - g0, 1);

    // full while idle: no grant until wrfull falls
    tick();
    bus.wrfull = 1'b1;
    target[0] = sent[0] + 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_hold%0d", i), bus.gnt, 4'b0000);
    end
    @(posedge clk);
    #2 bus.wrfull = 1'b0;
    @(negedge clk);
    chk("t4_still_idle", bus.gnt, 4'b0000);
    @(negedge clk);
    chk("t4_gnt", bus.gnt, 4'b0001);
    wait_drain("t4_drain");

    // owner 1 drops req exactly as its counter reaches MB-1
    tick();
    target[1] = sent[1] + (MB - 1);
    target[3] = sent[3] + 2;
    wait_acks(1, MB - 1, "t5_acks");
    @(negedge clk);
    chk("t5_hold_gnt", bus.gnt,   4'b0010);
    chk("t5_no_write", bus.wrreq, 0);
    @(negedge clk);
    chk("t5_bubble",   bus.gnt,   4'b0000);
    @(negedge clk);
    chk("t5_next_gnt", bus.gnt,   4'b1000);
    wait_drain("t5_drain");

    // asynchronous reset mid-burst
    tick();
    target[2] = sent[2] + 10;
    wait_acks(2, 2, "t6_pre");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_gnt",   bus.gnt,   0);
    chk("t6_wrreq", bus.wrreq, 0);
    chk("t6_ack",   bus.ack,   0);
    chk("t6_busy",  bus.busy,  0);
    chk("t6_owner", bus.owner, 3);
    target[0] = sent[0] + 2;
    target[1] = sent[1] + 2;
    target[3] = sent[3] + 2;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle", bus.gnt, 4'b0000);
    @(negedge clk);
    chk("t6_first", bus.gnt, 4'b0001);
    wait_drain("t6_drain");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
